// File: rtl/data_ram_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package data_ram_arb_pkg;

   localparam int   NUM_PORTS          = 2;
   localparam int   RAM_ADDR_W         = 8;
   localparam int   RAM_DATA_W         = 8;
   localparam logic DEFAULT_LAST_GRANT = 1'b1;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   typedef logic port_id_t;

   typedef struct packed {
      logic                  we;
      logic [RAM_ADDR_W-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic with a round-robin or fixed-priority policy.
// The grant is combinational; last_grant moves only when a grant is issued.
module rr_arbiter2
   import data_ram_arb_pkg::*;
(
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 enable,
   input  logic                 rr_en,
   output logic [NUM_PORTS-1:0] gnt,
   output port_id_t             gnt_id
);

   port_id_t last_grant;

   // Contention: alternate under round-robin, otherwise port 0 always wins.
   always_comb begin
      gnt_id = 1'b0;
      if (req == 2'b11)
         gnt_id = rr_en ? ~last_grant : 1'b0;
      else if (req[1])
         gnt_id = 1'b1;
      gnt = '0;
      if (enable && |req)
         gnt[gnt_id] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (Reset)
         last_grant <= DEFAULT_LAST_GRANT;
      else if (enable && |req)
         last_grant <= gnt_id;
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the load/store unit (port 0) and the
// test/DMA loader (port 1): one access per two cycles, registered response.
module data_ram_arbiter
   import data_ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter bit RR_EN  = 1'b1
)
(
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic [NUM_PORTS-1:0] req_valid,
   output logic [NUM_PORTS-1:0] req_ready,
   input  logic [NUM_PORTS-1:0] req_we,
   input  logic [ADDR_W-1:0]    req_addr0,
   input  logic [ADDR_W-1:0]    req_addr1,
   input  logic [DATA_W-1:0]    req_wdata0,
   input  logic [DATA_W-1:0]    req_wdata1,
   output logic [NUM_PORTS-1:0] rsp_valid,
   output logic [DATA_W-1:0]    rsp_rdata,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [ADDR_W-1:0]    mem_index,
   output logic [DATA_W-1:0]    write_value,
   input  logic [DATA_W-1:0]    read_value
);

   state_t              state;
   mem_req_t            sel_req;
   port_id_t            gnt_id;
   port_id_t            lat_id;
   logic [NUM_PORTS-1:0] gnt;
   logic                arb_en;
   logic                rd_q;
   logic                wr_q;

   assign arb_en = (state == IDLE) && !Reset;

   rr_arbiter2 u_arb (
      .CLK    (CLK),
      .Reset  (Reset),
      .req    (req_valid),
      .enable (arb_en),
      .rr_en  (RR_EN),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_ready = gnt;

   always_comb begin
      sel_req = '{we: req_we[0], addr: req_addr0, wdata: req_wdata0};
      if (gnt_id)
         sel_req = '{we: req_we[1], addr: req_addr1, wdata: req_wdata1};
   end

   // Reset must block a RAM write already committed to the ACCESS cycle.
   assign MemRead  = rd_q && !Reset;
   assign MemWrite = wr_q && !Reset;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state       <= IDLE;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         lat_id      <= 1'b0;
         mem_index   <= '0;
         write_value <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (|gnt) begin
                  mem_index   <= sel_req.addr;
                  write_value <= sel_req.wdata;
                  rd_q        <= !sel_req.we;
                  wr_q        <= sel_req.we;
                  lat_id      <= gnt_id;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               rd_q              <= 1'b0;
               wr_q              <= 1'b0;
               rsp_valid[lat_id] <= 1'b1;
               rsp_rdata         <= rd_q ? read_value : '0;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: a round-robin instance and a
// fixed-priority instance, each wired to its own 256x8 RAM model.
module tb_data_ram_arbiter;

   logic       CLK = 1'b0;
   logic       Reset;
   int         checks = 0;
   int         errors = 0;

   // Round-robin instance
   logic [1:0] valid, we, ready, rvalid;
   logic [7:0] a0, a1, d0, d1, rdata, idx, wval, rval;
   logic       mrd, mwr;
   logic [7:0] ram_rr [256];

   // Fixed-priority instance
   logic [1:0] fvalid, fwe, fready, frvalid;
   logic [7:0] fa0, fa1, fd0, fd1, frdata, fidx, fwval, frval;
   logic       fmrd, fmwr;
   logic [7:0] ram_fp [256];

   always #5 CLK = ~CLK;

   data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b1)) u_rr (
      .CLK(CLK), .Reset(Reset), .req_valid(valid), .req_ready(ready), .req_we(we),
      .req_addr0(a0), .req_addr1(a1), .req_wdata0(d0), .req_wdata1(d1),
      .rsp_valid(rvalid), .rsp_rdata(rdata), .MemRead(mrd), .MemWrite(mwr),
      .mem_index(idx), .write_value(wval), .read_value(rval)
   );

   data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b0)) u_fp (
      .CLK(CLK), .Reset(Reset), .req_valid(fvalid), .req_ready(fready), .req_we(fwe),
      .req_addr0(fa0), .req_addr1(fa1), .req_wdata0(fd0), .req_wdata1(fd1),
      .rsp_valid(frvalid), .rsp_rdata(frdata), .MemRead(fmrd), .MemWrite(fmwr),
      .mem_index(fidx), .write_value(fwval), .read_value(frval)
   );

   // RAM models: combinational read, write on the clock edge
   assign rval  = ram_rr[idx];
   assign frval = ram_fp[fidx];
   always @(posedge CLK) begin
      if (mwr)  ram_rr[idx]  <= wval;
      if (fmwr) ram_fp[fidx] <= fwval;
   end

   always @(negedge CLK) begin
      checks++;
      assert (!(mrd && mwr) && !(fmrd && fmwr)) else begin
         errors++;
         $error("FAIL enables_exclusive: observed rr=%b%b fp=%b%b required not both 1",
                mrd, mwr, fmrd, fmwr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   logic [7:0] acc;
   int         n0, n1, w;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_rr[i] = 8'(i) ^ 8'h5A;
         ram_fp[i] = 8'(i) ^ 8'h5A;
      end
      Reset = 1'b1;
      valid = '0; we = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      fvalid = '0; fwe = '0; fa0 = '0; fa1 = '0; fd0 = '0; fd1 = '0;

      // 1. reset for three cycles
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_ready",  32'(ready),  32'h0);
         chk("rst_rvalid", 32'(rvalid), 32'h0);
         chk("rst_rdata",  32'(rdata),  32'h0);
         chk("rst_enables", 32'({mrd, mwr, fmrd, fmwr}), 32'h0);
         chk("rst_index",  32'({idx, wval}), 32'h0);
         chk("rst_fp_out", 32'({fready, frvalid, frdata}), 32'h0);
      end
      Reset = 1'b0;

      // 2. port 0 write 0x10 <- 0xA5, then back-to-back read of 0x10
      valid = 2'b01; we = 2'b01; a0 = 8'h10; d0 = 8'hA5;
      #1 chk("t2_wr_ready", 32'(ready), 32'h1);
      tick();
      valid = 2'b00;
      chk("t2_wr_access", 32'({mwr, mrd}), 32'h2);
      chk("t2_wr_index",  32'(idx), 32'h10);
      chk("t2_wr_value",  32'(wval), 32'hA5);
      chk("t2_wr_rvalid", 32'(rvalid), 32'h0);
      chk("t2_busy_ready", 32'(ready), 32'h0);
      tick();
      chk("t2_wr_ack",    32'(rvalid), 32'h1);
      chk("t2_wr_rdata",  32'(rdata), 32'h0);
      chk("t2_wr_ram",    32'(ram_rr[8'h10]), 32'hA5);
      chk("t2_idle_en",   32'({mwr, mrd}), 32'h0);
      chk("t2_idx_hold",  32'(idx), 32'h10);
      valid = 2'b01; we = 2'b00; a0 = 8'h10;
      #1 chk("t6_b2b_ready", 32'(ready), 32'h1);
      tick();
      valid = 2'b00;
      chk("t2_rd_access", 32'({mwr, mrd}), 32'h1);
      tick();
      chk("t2_rd_rvalid", 32'(rvalid), 32'h1);
      chk("t2_rd_rdata",  32'(rdata), 32'hA5);

      // 5. port 1 write 0xFF <- 0x3C, reset lands in the ACCESS cycle
      valid = 2'b10; we = 2'b10; a1 = 8'hFF; d1 = 8'h3C;
      #1 chk("t5_ready", 32'(ready), 32'h2);
      tick();
      valid = 2'b00;
      chk("t5_access_wr", 32'(mwr), 32'h1);
      chk("t5_access_idx", 32'(idx), 32'hFF);
      Reset = 1'b1;
      #1 chk("t5_gated_wr", 32'({mwr, mrd}), 32'h0);
      tick();
      Reset = 1'b0;
      chk("t5_no_rsp", 32'(rvalid), 32'h0);
      chk("t5_ram_kept", 32'(ram_rr[8'hFF]), 32'hA5);
      valid = 2'b10; we = 2'b00; a1 = 8'hFF;
      #1 chk("t5_reaccept", 32'(ready), 32'h2);
      tick();
      valid = 2'b00;
      chk("t5_rd_access", 32'({mrd, idx}), 32'h1FF);
      tick();
      chk("t5_rd_rvalid", 32'(rvalid), 32'h2);
      chk("t5_rd_rdata",  32'(rdata), 32'hA5);

      // 3. round-robin, both ports reading four addresses each
      n0 = 0; n1 = 0;
      valid = 2'b11; we = 2'b00; a0 = 8'h20; a1 = 8'h40;
      for (int g = 0; g < 8; g++) begin
         w = g % 2;
         #1 chk("t3_ready", 32'(ready), 32'(1 << w));
         acc = (w == 1) ? a1 : a0;
         tick();
         if (w == 0) begin
            n0++;
            a0 = 8'(8'h20 + n0);
            if (n0 == 4) valid[0] = 1'b0;
         end else begin
            n1++;
            a1 = 8'(8'h40 + n1);
            if (n1 == 4) valid[1] = 1'b0;
         end
         chk("t3_busy_ready", 32'(ready), 32'h0);
         chk("t3_access", 32'({mrd, idx}), 32'({1'b1, acc}));
         tick();
         chk("t3_rvalid", 32'(rvalid), 32'(1 << w));
         chk("t3_rdata",  32'(rdata),  32'(acc ^ 8'h5A));
      end

      // 4. fixed priority: port 1 starves while port 0 stays valid
      fvalid = 2'b11; fwe = 2'b00; fa0 = 8'h30; fa1 = 8'h50;
      for (int g = 0; g < 3; g++) begin
         #1 chk("t4_ready", 32'(fready), 32'h1);
         acc = fa0;
         tick();
         fa0 = 8'(fa0 + 1);
         if (g == 2) fvalid[0] = 1'b0;
         chk("t4_access", 32'({fmrd, fidx}), 32'({1'b1, acc}));
         tick();
         chk("t4_rvalid", 32'(frvalid), 32'h1);
         chk("t4_rdata",  32'(frdata), 32'(acc ^ 8'h5A));
      end
      #1 chk("t4_p1_ready", 32'(fready), 32'h2);
      tick();
      fvalid = 2'b00;
      tick();
      chk("t4_p1_rvalid", 32'(frvalid), 32'h2);
      chk("t4_p1_rdata",  32'(frdata), 32'h0A);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
